// File: rtl/fpu_operand_align.sv
// Operand alignment front end for the FP adder. It classifies both operands, orders them by
// magnitude and right-aligns the smaller significand with guard/round/sticky bits (two stages).
module fpu_operand_align #(
    parameter int unsigned EXP_W  = 8,
    parameter int unsigned FRAC_W = 23,
    localparam int unsigned W     = 1 + EXP_W + FRAC_W,
    localparam int unsigned M     = FRAC_W + 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [W-1:0]     x_i,
    input  logic [W-1:0]     y_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic             big_sign_o,
    output logic             small_sign_o,
    output logic [EXP_W-1:0] big_exp_o,
    output logic [EXP_W-1:0] exp_diff_o,
    output logic [M-1:0]     big_mant_o,
    output logic [M-1:0]     small_mant_o,
    output logic             swapped_o,
    output logic             x_zero_o,
    output logic             y_zero_o,
    output logic             x_inf_o,
    output logic             y_inf_o,
    output logic             x_nan_o,
    output logic             y_nan_o
);

    logic in_xfer, s1_adv, out_xfer;

    logic               s1_valid_q, s1_valid_d;
    logic               s1_big_sign_q, s1_big_sign_d;
    logic               s1_small_sign_q, s1_small_sign_d;
    logic               s1_swapped_q, s1_swapped_d;
    logic [EXP_W-1:0]   s1_big_exp_q, s1_big_exp_d;
    logic [EXP_W-1:0]   s1_exp_diff_q, s1_exp_diff_d;
    logic [FRAC_W:0]    s1_big_sig_q, s1_big_sig_d;
    logic [FRAC_W:0]    s1_small_sig_q, s1_small_sig_d;
    logic [5:0]         s1_flags_q, s1_flags_d;

    logic               s2_valid_q, s2_valid_d;
    logic               s2_big_sign_q, s2_small_sign_q, s2_swapped_q;
    logic [EXP_W-1:0]   s2_big_exp_q, s2_exp_diff_q;
    logic [M-1:0]       s2_big_mant_q, s2_big_mant_d;
    logic [M-1:0]       s2_small_mant_q, s2_small_mant_d;
    logic [5:0]         s2_flags_q;

    logic [EXP_W-1:0]   x_exp, y_exp, x_eff, y_eff, small_eff;
    logic [FRAC_W-1:0]  x_frac, y_frac;
    logic [FRAC_W:0]    x_sig, y_sig;
    logic [M-1:0]       ext, lost_mask;

    assign out_xfer = s2_valid_q && ready_i;
    assign s1_adv   = s1_valid_q && (!s2_valid_q || ready_i);
    assign ready_o  = !s1_valid_q || s1_adv;
    assign in_xfer  = valid_i && ready_o;

    always_comb begin
        s1_valid_d = s1_valid_q;
        if (in_xfer) begin
            s1_valid_d = 1'b1;
        end else if (s1_adv) begin
            s1_valid_d = 1'b0;
        end
        s2_valid_d = s2_valid_q;
        if (s1_adv) begin
            s2_valid_d = 1'b1;
        end else if (out_xfer) begin
            s2_valid_d = 1'b0;
        end
    end

    // Stage 1: classify, order by magnitude, compute exponent difference.
    always_comb begin
        x_exp  = x_i[W-2 -: EXP_W];
        y_exp  = y_i[W-2 -: EXP_W];
        x_frac = x_i[FRAC_W-1:0];
        y_frac = y_i[FRAC_W-1:0];
        x_eff  = (x_exp == '0) ? EXP_W'(1) : x_exp;
        y_eff  = (y_exp == '0) ? EXP_W'(1) : y_exp;
        x_sig  = {x_exp != '0, x_frac};
        y_sig  = {y_exp != '0, y_frac};

        s1_swapped_d = y_i[W-2:0] > x_i[W-2:0];
        if (s1_swapped_d) begin
            s1_big_sign_d   = y_i[W-1];
            s1_small_sign_d = x_i[W-1];
            s1_big_exp_d    = y_eff;
            small_eff       = x_eff;
            s1_big_sig_d    = y_sig;
            s1_small_sig_d  = x_sig;
        end else begin
            s1_big_sign_d   = x_i[W-1];
            s1_small_sign_d = y_i[W-1];
            s1_big_exp_d    = x_eff;
            small_eff       = y_eff;
            s1_big_sig_d    = x_sig;
            s1_small_sig_d  = y_sig;
        end
        s1_exp_diff_d = s1_big_exp_d - small_eff;

        s1_flags_d = {(x_exp == '0) && (x_frac == '0),
                      (y_exp == '0) && (y_frac == '0),
                      (x_exp == '1) && (x_frac == '0),
                      (y_exp == '1) && (y_frac == '0),
                      (x_exp == '1) && (x_frac != '0),
                      (y_exp == '1) && (y_frac != '0)};
    end

    // Stage 2: right-align the smaller significand, folding shifted-out bits into sticky.
    always_comb begin
        ext             = {s1_small_sig_q, 3'b000};
        lost_mask       = '0;
        s2_big_mant_d   = {s1_big_sig_q, 3'b000};
        s2_small_mant_d = '0;
        if (32'(s1_exp_diff_q) >= M) begin
            s2_small_mant_d = {{(M-1){1'b0}}, |s1_small_sig_q};
        end else begin
            lost_mask          = ~({M{1'b1}} << s1_exp_diff_q);
            s2_small_mant_d    = ext >> s1_exp_diff_q;
            s2_small_mant_d[0] = s2_small_mant_d[0] | (|(ext & lost_mask));
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            s1_valid_q      <= 1'b0;
            s1_big_sign_q   <= 1'b0;
            s1_small_sign_q <= 1'b0;
            s1_swapped_q    <= 1'b0;
            s1_big_exp_q    <= '0;
            s1_exp_diff_q   <= '0;
            s1_big_sig_q    <= '0;
            s1_small_sig_q  <= '0;
            s1_flags_q      <= '0;
            s2_valid_q      <= 1'b0;
            s2_big_sign_q   <= 1'b0;
            s2_small_sign_q <= 1'b0;
            s2_swapped_q    <= 1'b0;
            s2_big_exp_q    <= '0;
            s2_exp_diff_q   <= '0;
            s2_big_mant_q   <= '0;
            s2_small_mant_q <= '0;
            s2_flags_q      <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s2_valid_q <= s2_valid_d;
            if (in_xfer) begin
                s1_big_sign_q   <= s1_big_sign_d;
                s1_small_sign_q <= s1_small_sign_d;
                s1_swapped_q    <= s1_swapped_d;
                s1_big_exp_q    <= s1_big_exp_d;
                s1_exp_diff_q   <= s1_exp_diff_d;
                s1_big_sig_q    <= s1_big_sig_d;
                s1_small_sig_q  <= s1_small_sig_d;
                s1_flags_q      <= s1_flags_d;
            end
            if (s1_adv) begin
                s2_big_sign_q   <= s1_big_sign_q;
                s2_small_sign_q <= s1_small_sign_q;
                s2_swapped_q    <= s1_swapped_q;
                s2_big_exp_q    <= s1_big_exp_q;
                s2_exp_diff_q   <= s1_exp_diff_q;
                s2_big_mant_q   <= s2_big_mant_d;
                s2_small_mant_q <= s2_small_mant_d;
                s2_flags_q      <= s1_flags_q;
            end
        end
    end

    assign valid_o      = s2_valid_q;
    assign big_sign_o   = s2_big_sign_q;
    assign small_sign_o = s2_small_sign_q;
    assign swapped_o    = s2_swapped_q;
    assign big_exp_o    = s2_big_exp_q;
    assign exp_diff_o   = s2_exp_diff_q;
    assign big_mant_o   = s2_big_mant_q;
    assign small_mant_o = s2_small_mant_q;
    assign {x_zero_o, y_zero_o, x_inf_o, y_inf_o, x_nan_o, y_nan_o} = s2_flags_q;

endmodule

// File: tb/tb_fpu_operand_align.sv
// Randomised and directed bench for fpu_operand_align (FP32), scoreboarded against a numeric
// model of the alignment rules.
module tb_fpu_operand_align;

    localparam int unsigned EXP_W  = 8;
    localparam int unsigned FRAC_W = 23;
    localparam int unsigned W      = 32;
    localparam int unsigned M      = 27;

    logic             clk = 1'b0;
    logic             rst_i;
    logic             valid_i, ready_o, valid_o, ready_i;
    logic [W-1:0]     x_i, y_i;
    logic             big_sign_o, small_sign_o, swapped_o;
    logic [EXP_W-1:0] big_exp_o, exp_diff_o;
    logic [M-1:0]     big_mant_o, small_mant_o;
    logic             x_zero_o, y_zero_o, x_inf_o, y_inf_o, x_nan_o, y_nan_o;

    fpu_operand_align #(.EXP_W(EXP_W), .FRAC_W(FRAC_W)) dut (
        .clk_i(clk), .rst_i(rst_i), .valid_i(valid_i), .ready_o(ready_o),
        .x_i(x_i), .y_i(y_i), .valid_o(valid_o), .ready_i(ready_i),
        .big_sign_o(big_sign_o), .small_sign_o(small_sign_o), .big_exp_o(big_exp_o),
        .exp_diff_o(exp_diff_o), .big_mant_o(big_mant_o), .small_mant_o(small_mant_o),
        .swapped_o(swapped_o), .x_zero_o(x_zero_o), .y_zero_o(y_zero_o), .x_inf_o(x_inf_o),
        .y_inf_o(y_inf_o), .x_nan_o(x_nan_o), .y_nan_o(y_nan_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit               bs, ss, sw;
        longint unsigned  be, ed, bm, sm;
        bit [5:0]         flags;
    } exp_t;

    exp_t        sb[$];
    int unsigned n_checks = 0;
    int unsigned n_errors = 0;
    bit          popped, held;
    logic [79:0] snap;
    exp_t        cap;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s got=%0h want=%0h", tag, got, want);
        end
    endtask

    // Numeric restatement of the rules: value of significand, shift by division, sticky by modulo.
    function automatic exp_t model(input logic [31:0] x, input logic [31:0] y);
        exp_t            r;
        longint unsigned xe, ye, xf, yf, xs, ys, xeff, yeff, ss, ext, se;
        xe   = longint'(x[30:23]);
        ye   = longint'(y[30:23]);
        xf   = longint'(x[22:0]);
        yf   = longint'(y[22:0]);
        xs   = (xe != 0 ? 64'd8388608 : 64'd0) + xf;
        ys   = (ye != 0 ? 64'd8388608 : 64'd0) + yf;
        xeff = (xe == 0) ? 1 : xe;
        yeff = (ye == 0) ? 1 : ye;
        r.sw = (ye * 64'd8388608 + yf) > (xe * 64'd8388608 + xf);
        r.bs = r.sw ? y[31] : x[31];
        r.ss = r.sw ? x[31] : y[31];
        r.be = r.sw ? yeff : xeff;
        se   = r.sw ? xeff : yeff;
        r.ed = r.be - se;
        r.bm = (r.sw ? ys : xs) * 8;
        ss   = r.sw ? xs : ys;
        ext  = ss * 8;
        if (r.ed >= M) r.sm = (ss != 0) ? 1 : 0;
        else begin
            r.sm = ext / (64'd1 << r.ed);
            if ((ext % (64'd1 << r.ed)) != 0) r.sm = r.sm | 1;
        end
        r.flags = {xe == 0 && xf == 0, ye == 0 && yf == 0, xe == 255 && xf == 0,
                   ye == 255 && yf == 0, xe == 255 && xf != 0, ye == 255 && yf != 0};
        return r;
    endfunction

    function automatic logic [31:0] rnd_op();
        logic [7:0]  e;
        logic [22:0] f;
        case ($urandom_range(0, 5))
            0:       e = 8'h00;
            1:       e = 8'hFF;
            2:       e = 8'h01;
            default: e = 8'($urandom);
        endcase
        f = ($urandom_range(0, 3) == 0) ? 23'd0 : 23'($urandom);
        return {1'($urandom), e, f};
    endfunction

    function automatic logic [79:0] outvec();
        return {valid_o, big_sign_o, small_sign_o, big_exp_o, exp_diff_o, big_mant_o,
                small_mant_o, swapped_o, x_zero_o, y_zero_o, x_inf_o, y_inf_o, x_nan_o, y_nan_o};
    endfunction

    // One clock: drive at negedge, settle, account the transfers that happen at the next posedge.
    task automatic cycle(input bit rdy, input bit vld, input logic [31:0] xa, input logic [31:0] ya);
        exp_t e;
        ready_i = rdy;
        valid_i = vld;
        x_i     = xa;
        y_i     = ya;
        #1;
        popped = 0;
        if (held) check("hold_stable", outvec(), snap);
        if (vld && ready_o) sb.push_back(model(xa, ya));
        if (valid_o && ready_i) begin
            if (sb.size() == 0) begin
                check("spurious_valid", valid_o, 1'b0);
            end else begin
                e = sb.pop_front();
                check("swapped", swapped_o, e.sw);
                check("big_sign", big_sign_o, e.bs);
                check("small_sign", small_sign_o, e.ss);
                check("big_exp", big_exp_o, e.be);
                check("exp_diff", exp_diff_o, e.ed);
                check("big_mant", big_mant_o, e.bm);
                check("small_mant", small_mant_o, e.sm);
                check("flags", {x_zero_o, y_zero_o, x_inf_o, y_inf_o, x_nan_o, y_nan_o}, e.flags);
                cap    = e;
                popped = 1;
            end
        end
        held = valid_o && !ready_i;
        snap = outvec();
        @(negedge clk);
    endtask

    // Issue one pair with ready_i=1 and require the result exactly two cycles later.
    task automatic run_pair(input logic [31:0] xa, input logic [31:0] ya);
        int lat;
        cycle(1'b1, 1'b1, xa, ya);
        lat = 0;
        while (!popped && lat < 6) begin
            lat++;
            cycle(1'b1, 1'b0, '0, '0);
        end
        check("latency", lat, 2);
    endtask

    initial begin
        rst_i   = 1'b1;
        valid_i = 1'b0;
        ready_i = 1'b0;
        x_i     = '0;
        y_i     = '0;
        held    = 0;
        @(negedge clk);
        check("reset_outputs", outvec(), 80'd0);
        rst_i = 1'b0;
        #1;
        check("reset_ready", ready_o, 1'b1);
        @(negedge clk);

        run_pair(32'h4040_0000, 32'h3F80_0000);
        check("d1_swapped", swapped_o, 1'b0);
        check("d1_big_exp", big_exp_o, 128);
        check("d1_exp_diff", exp_diff_o, 1);
        check("d1_big_mant", big_mant_o, 27'h600_0000);
        check("d1_small_mant", small_mant_o, 27'h200_0000);
        run_pair(32'h3F80_0000, 32'hC040_0000);
        check("d2_swapped", swapped_o, 1'b1);
        check("d2_signs", {big_sign_o, small_sign_o}, 2'b10);
        check("d2_mants", {big_mant_o, small_mant_o}, {27'h600_0000, 27'h200_0000});
        run_pair(32'h3F80_0000, 32'hBF80_0000);
        check("d3_tie", {swapped_o, exp_diff_o}, 9'd0);
        run_pair(32'h4B80_0000, 32'h3F80_0001);
        check("d4_exp_diff", exp_diff_o, 24);
        check("d4_sticky", small_mant_o, 27'h5);
        run_pair(32'h7F00_0000, 32'h0000_0001);
        check("d5_exp_diff", exp_diff_o, 253);
        check("d5_saturate", small_mant_o, 27'h1);
        run_pair(32'h7F00_0000, 32'h0000_0000);
        check("d6_zero", {small_mant_o, y_zero_o}, {27'h0, 1'b1});
        run_pair(32'h0080_0000, 32'h0000_0001);
        check("d7_subnormal", {big_exp_o, exp_diff_o, small_mant_o}, {8'd1, 8'd0, 27'h8});
        run_pair(32'h7FC0_0000, 32'hFF80_0000);
        check("d8_specials", {x_nan_o, y_inf_o, y_nan_o}, 3'b110);

        // Backpressure: two pairs fill the pipe, the third is refused until ready_i rises.
        #1;
        check("bp_ready0", ready_o, 1'b1);
        cycle(1'b0, 1'b1, 32'h4000_0000, 32'h3F00_0000);
        #1;
        check("bp_ready1", ready_o, 1'b1);
        cycle(1'b0, 1'b1, 32'hC100_0000, 32'h4120_0000);
        #1;
        check("bp_ready2", ready_o, 1'b0);
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 32'h4280_0000, 32'h0000_0003);
        check("bp_held_pairs", sb.size(), 2);
        cycle(1'b1, 1'b1, 32'h4280_0000, 32'h0000_0003);
        check("bp_first_out", popped, 1'b1);
        check("bp_third_in", sb.size(), 2);
        for (int i = 0; i < 2; i++) begin
            cycle(1'b1, 1'b0, '0, '0);
            check("bp_in_order", popped, 1'b1);
        end
        check("bp_drained", sb.size(), 0);

        // Randomised traffic with random backpressure.
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] xa, ya;
            xa = rnd_op();
            ya = ($urandom_range(0, 7) == 0) ? (xa ^ 32'h8000_0000) : rnd_op();
            cycle($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 7, xa, ya);
        end
        for (int i = 0; i < 6; i++) cycle(1'b1, 1'b0, '0, '0);
        check("rnd_drained", sb.size(), 0);

        // Reset with both stages full must drop valid_o without waiting for a clock edge.
        cycle(1'b0, 1'b1, 32'h4040_0000, 32'h3F80_0000);
        cycle(1'b0, 1'b1, 32'h4040_0000, 32'h3F80_0000);
        check("rst_full", {valid_o, ready_o}, 2'b10);
        #2;
        rst_i = 1'b1;
        #1;
        check("rst_async_valid", valid_o, 1'b0);
        check("rst_async_outs", outvec(), 80'd0);
        @(negedge clk);
        rst_i = 1'b0;
        sb.delete();
        held = 0;
        #1;
        check("rst_ready", ready_o, 1'b1);
        for (int i = 0; i < 4; i++) begin
            cycle(1'b1, 1'b0, '0, '0);
            check("rst_no_stale", valid_o, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

endmodule
